// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle two's-complement adder/subtractor, CHUNK bits per
// clock, least-significant chunk first, with the ripple carry kept in a
// register between cycles.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits processed per RUN cycle (>= 1, divides WIDTH)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (ready only in IDLE)
//   a, b, add0_sub1      operands and mode (0 = A+B, 1 = A-B)
//   out_valid/out_ready  result handshake
//   sd                   sum/difference modulo 2^WIDTH
//   co                   carry out of MSB (subtract: 1 = no borrow)
//   err                  signed overflow
//   zero                 raw result == 0
//   busy                 high in RUN or DONE
//
// Optional build macro:
//   SEQ_ADDSUB_SATURATE_EN  clamp sd on signed overflow; flags still
//                           describe the unsaturated result.

module seq_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add0_sub1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sd,
    output logic             co,
    output logic             err,
    output logic             zero,
    output logic             busy
);

    localparam int N    = WIDTH / CHUNK;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             co_q, co_d;
    logic             err_q, err_d;
    logic             zero_q, zero_d;

    // Working values for the chunk processed this cycle.
    int               off;
    logic [CHUNK:0]   sum_c;
    logic [WIDTH-1:0] sd_n;
    logic             ovf;

    assign off = int'(cnt_q) * CHUNK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            bx_q    <= '0;
            sd_q    <= '0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            sd_q    <= sd_d;
            co_q    <= co_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        bx_d    = bx_q;
        sd_d    = sd_q;
        co_d    = co_q;
        err_d   = err_q;
        zero_d  = zero_q;
        sum_c   = '0;
        sd_n    = sd_q;
        ovf     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtract as A + ~B + 1: the +1 enters as carry-in.
                    bx_d    = add0_sub1 ? ~b : b;
                    carry_d = add0_sub1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_c = {1'b0, a_q[off +: CHUNK]}
                      + {1'b0, bx_q[off +: CHUNK]}
                      + {{CHUNK{1'b0}}, carry_q};
                sd_n[off +: CHUNK] = sum_c[CHUNK-1:0];
                sd_d    = sd_n;
                carry_d = sum_c[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    ovf = (a_q[WIDTH-1] == bx_q[WIDTH-1])
                       && (sd_n[WIDTH-1] != a_q[WIDTH-1]);
                    co_d    = sum_c[CHUNK];
                    err_d   = ovf;
                    zero_d  = (sd_n == '0);
`ifdef SEQ_ADDSUB_SATURATE_EN
                    if (ovf) begin
                        sd_d = a_q[WIDTH-1]
                             ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sd        = sd_q;
    assign co        = co_q;
    assign err       = err_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: drives four seq_addsub instances (WIDTH=8, CHUNK=1,2,4,8)
// and compares every result against a plain-arithmetic reference model.

module tb_seq_addsub;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid_v  [4];
    logic       out_ready_v [4];
    logic       add_v       [4];
    logic [7:0] a_v         [4];
    logic [7:0] b_v         [4];
    logic       in_ready_v  [4];
    logic       out_valid_v [4];
    logic       co_v        [4];
    logic       err_v       [4];
    logic       zero_v      [4];
    logic       busy_v      [4];
    logic [7:0] sd_v        [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            seq_addsub #(
                .WIDTH(8),
                .CHUNK(1 << g)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid_v[g]),
                .in_ready (in_ready_v[g]),
                .a        (a_v[g]),
                .b        (b_v[g]),
                .add0_sub1(add_v[g]),
                .out_valid(out_valid_v[g]),
                .out_ready(out_ready_v[g]),
                .sd       (sd_v[g]),
                .co       (co_v[g]),
                .err      (err_v[g]),
                .zero     (zero_v[g]),
                .busy     (busy_v[g])
            );
        end
    endgenerate

    // Reference: {sd, co, err, zero} from integer arithmetic.
    function automatic logic [10:0] model(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic       s);
        int ua, ub, sa, sb, us, ss;
        logic [7:0] r;
        logic c, e, z;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        us = s ? (ua - ub) : (ua + ub);
        ss = s ? (sa - sb) : (sa + sb);
        c  = s ? (ua >= ub) : (us > 255);
        e  = (ss > 127) || (ss < -128);
        r  = 8'(us & 255);
        z  = (r == 8'h00);
`ifdef SEQ_ADDSUB_SATURATE_EN
        if (e) r = (ss > 127) ? 8'h7F : 8'h80;
`endif
        return {r, c, e, z};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int k, input logic [7:0] a,
                            input logic [7:0] b, input logic s);
        int n;
        n = 0;
        while (!in_ready_v[k] && n < 50) begin
            step();
            n++;
        end
        chk("idle_ready", 32'(in_ready_v[k]), 32'd1);
        a_v[k]        = a;
        b_v[k]        = b;
        add_v[k]      = s;
        in_valid_v[k] = 1'b1;
        step();
        in_valid_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (!out_valid_v[k] && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic check_result(input int k, input logic [7:0] a,
                                input logic [7:0] b, input logic s,
                                input int lat, input string tag);
        logic [10:0] e;
        e = model(a, b, s);
        chk({tag, "_lat"}, 32'(lat), 32'(8 >> k));
        chk({tag, "_ovalid"}, 32'(out_valid_v[k]), 32'd1);
        chk({tag, "_busy"}, 32'(busy_v[k]), 32'd1);
        chk({tag, "_sd"}, 32'(sd_v[k]), 32'(e[10:3]));
        chk({tag, "_co"}, 32'(co_v[k]), 32'(e[2]));
        chk({tag, "_err"}, 32'(err_v[k]), 32'(e[1]));
        chk({tag, "_zero"}, 32'(zero_v[k]), 32'(e[0]));
    endtask

    task automatic handshake(input int k, input string tag);
        out_ready_v[k] = 1'b1;
        step();
        out_ready_v[k] = 1'b0;
        chk({tag, "_hs_ovalid"}, 32'(out_valid_v[k]), 32'd0);
        chk({tag, "_hs_iready"}, 32'(in_ready_v[k]), 32'd1);
    endtask

    task automatic run_op(input int k, input logic [7:0] a,
                          input logic [7:0] b, input logic s,
                          input string tag);
        int lat;
        start_op(k, a, b, s);
        wait_done(k, lat);
        check_result(k, a, b, s, lat, tag);
        handshake(k, tag);
    endtask

    initial begin
        logic [10:0] e;
        logic [7:0]  ra, rb;
        logic        rs;
        int          lat;

        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b0;
            add_v[k]       = 1'b0;
            a_v[k]         = 8'h00;
            b_v[k]         = 8'h00;
        end
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst%0d_iready", k), 32'(in_ready_v[k]), 32'd1);
            chk($sformatf("rst%0d_ovalid", k), 32'(out_valid_v[k]), 32'd0);
            chk($sformatf("rst%0d_sd", k), 32'(sd_v[k]), 32'd0);
            chk($sformatf("rst%0d_co", k), 32'(co_v[k]), 32'd0);
            chk($sformatf("rst%0d_err", k), 32'(err_v[k]), 32'd0);
            chk($sformatf("rst%0d_zero", k), 32'(zero_v[k]), 32'd0);
            chk($sformatf("rst%0d_busy", k), 32'(busy_v[k]), 32'd0);
        end
        rst = 1'b0;
        step();

        // Directed cases on CHUNK=2.
        run_op(1, 8'h01, 8'hFF, 1'b0, "add_wrap");
        chk("add_wrap_lit_sd", 32'(model(8'h01, 8'hFF, 1'b0) >> 3), 32'h00);
        run_op(1, 8'h7F, 8'h01, 1'b0, "add_ovf");
        run_op(1, 8'h05, 8'h07, 1'b1, "sub_neg");
        run_op(1, 8'h80, 8'h01, 1'b1, "sub_minneg");
        run_op(1, 8'h5A, 8'h00, 1'b1, "sub_b0");
        run_op(1, 8'h3C, 8'h3C, 1'b1, "sub_eq");
        run_op(1, 8'h80, 8'h80, 1'b0, "add_negneg");

        // Backpressure: DONE held while new operands are offered.
        e = model(8'h05, 8'h07, 1'b1);
        start_op(1, 8'h05, 8'h07, 1'b1);
        wait_done(1, lat);
        check_result(1, 8'h05, 8'h07, 1'b1, lat, "bp");
        for (int i = 0; i < 3; i++) begin
            a_v[1]        = 8'hAA;
            b_v[1]        = 8'h11;
            add_v[1]      = 1'b0;
            in_valid_v[1] = 1'b1;
            step();
            chk($sformatf("bp%0d_iready", i), 32'(in_ready_v[1]), 32'd0);
            chk($sformatf("bp%0d_ovalid", i), 32'(out_valid_v[1]), 32'd1);
            chk($sformatf("bp%0d_sd", i), 32'(sd_v[1]), 32'(e[10:3]));
            chk($sformatf("bp%0d_co", i), 32'(co_v[1]), 32'(e[2]));
            chk($sformatf("bp%0d_err", i), 32'(err_v[1]), 32'(e[1]));
            chk($sformatf("bp%0d_zero", i), 32'(zero_v[1]), 32'(e[0]));
        end
        in_valid_v[1] = 1'b0;
        handshake(1, "bp");
        step();
        chk("bp_idle_busy", 32'(busy_v[1]), 32'd0);
        chk("bp_idle_sd", 32'(sd_v[1]), 32'(e[10:3]));

        // Reset during the second RUN cycle.
        start_op(1, 8'h12, 8'h34, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_iready", 32'(in_ready_v[1]), 32'd1);
        chk("mrst_ovalid", 32'(out_valid_v[1]), 32'd0);
        chk("mrst_sd", 32'(sd_v[1]), 32'd0);
        chk("mrst_co", 32'(co_v[1]), 32'd0);
        chk("mrst_err", 32'(err_v[1]), 32'd0);
        chk("mrst_zero", 32'(zero_v[1]), 32'd0);
        chk("mrst_busy", 32'(busy_v[1]), 32'd0);
        step();
        run_op(1, 8'h10, 8'h20, 1'b0, "post_rst");

        // Random sweep over every CHUNK.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 128; i++) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rs = 1'($urandom_range(0, 1));
                run_op(k, ra, rb, rs, $sformatf("rnd_c%0d_%0d", 1 << k, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor. Successor to the fixed 8-bit combinational add/sub unit.
- Processes CHUNK bits per clock, least-significant chunk first, with a ripple carry held in a register between cycles.
- Operands arrive on a valid/ready input handshake. The result leaves on a valid/ready output handshake with carry, signed-overflow and zero flags.
- Sits between the operand register file and the result writeback stage in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be at least 2.
- CHUNK, 2, bits processed per cycle. Must be at least 1 and divide WIDTH. CHUNK = WIDTH gives a single-cycle RUN phase.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- add0_sub1  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- sd  out  WIDTH  sum/difference, modulo 2^WIDTH.
- co  out  1  carry out of the MSB. For subtract, 1 = no borrow.
- err  out  1  signed overflow.
- zero  out  1  sd == 0. Computed on the raw result, before any saturation.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=1; out_valid=0; sd=0; co=0; err=0; zero=0; busy=0. Internal chunk counter=0, carry=0, state=IDLE.
- Reset mid-operation: any in-flight operation is discarded. Outputs return to reset values on the next edge, with no partial result visible.
- N = WIDTH/CHUNK. States are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch A, and Bx = add0_sub1 ? ~B : B. Set carry = add0_sub1 and count = 0. Go to RUN.
  - a/b/add0_sub1 are sampled only on the accepting edge.
- RUN:
  - Each cycle, {carry, chunk} = A[chunk k] + Bx[chunk k] + carry, with the chunk written into sd[chunk k]. Then count++.
  - After chunk N-1: co = final carry; err = (A[MSB]==Bx[MSB]) && (sd[MSB]!=A[MSB]); zero = (sd==0). Go to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid=1. sd and flags are held stable until the handshake.
  - When out_valid && out_ready, go to IDLE on that edge and drop out_valid. in_ready rises in the same cycle.
  - No bypass: a new accept needs at least one cycle in IDLE.
- Latency: out_valid rises exactly N edges after the accepting edge (WIDTH=8, CHUNK=2 gives 4). Throughput is one operation per N+2 cycles minimum.
- Output hold: sd and flags keep their last values in IDLE. They are updated progressively during RUN and are valid only while out_valid=1.
- Arithmetic edge cases:
  - B=0 with subtract gives co=1.
  - A=B with subtract gives sd=0, zero=1, co=1.
  - Most-negative minus 1 gives err=1.

Optional Feature:
- Macro: SEQ_ADDSUB_SATURATE_EN.
- Defined: when the computed err=1, the registered sd is clamped at the end of RUN.
  - A[MSB]=0 clamps to the max positive value (0 followed by all 1s).
  - A[MSB]=1 clamps to the min negative value (1 followed by all 0s).
  - err, co and zero still reflect the unsaturated result.
- Undefined: sd wraps modulo 2^WIDTH, and no clamping logic is instantiated.

Test Plan:
- WIDTH=8, CHUNK=2, A=0x01, B=0xFF, add → sd=0x00, co=1, err=0, zero=1. out_valid exactly 4 edges after accept.
- A=0x7F, B=0x01, add → sd=0x80, co=0, err=1. With SEQ_ADDSUB_SATURATE_EN: sd=0x7F, err=1.
- A=0x05, B=0x07, sub → sd=0xFE, co=0, err=0, zero=0. Then A=0x80, B=0x01, sub → sd=0x7F, co=1, err=1 (saturated build: sd=0x80).
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, pulsing in_valid with new operands → sd/flags stable, in_ready=0, new operands not captured. Release → one handshake, back to IDLE.
- Assert rst on the 2nd RUN cycle → next edge all outputs at reset values, in_ready=1. A following A=0x10, B=0x20 add gives sd=0x30.
- Sweep CHUNK∈{1,2,4,8} with WIDTH=8 and 128 random operands/modes each → sd matches A±B mod 256, co/err match reference model, latency = 8/CHUNK.
